// File: rtl/hacd_axi_mem_pkg.sv
// Shared types and helpers for the HACD AXI4 slave memory model.
// Holds response codes, channel FSM state encodings and beat address math.
// No logic lives here; everything is combinational helpers.
package hacd_axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LAT  = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // Word index of beat k of an INCR burst. Beat strides are whole words, so
  // shifting the start address first is exact and avoids carry overflow.
  function automatic logic [63:0] beat_index(input logic [63:0] addr,
                                             input logic [7:0]  k,
                                             input int unsigned lg_bytes);
    return (addr >> lg_bytes) + 64'(k);
  endfunction

endpackage

// File: rtl/hacd_axi_mem_ram.sv
// DEPTH x DATA_W storage: one byte-enabled write port, one combinational read port.
// Write lands at the clock edge; read is same-cycle, so a read at a write edge sees old data.
// No flow control; the caller decides when to write and where to read.
module hacd_axi_mem_ram #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hacd_axi4_mem_model.sv
// AXI4 slave memory with independent write (AW/W/B) and read (AR/R) burst engines.
// Read: first R beat RD_LATENCY+1 cycles after AR handshake, then one beat per cycle.
// Backpressure: one burst outstanding per direction; R/B outputs hold while ready is low.
module hacd_axi4_mem_model
  import hacd_axi_mem_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 4,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [ID_W-1:0]     axi_awid,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  output logic [1:0]          axi_bresp,
  output logic [ID_W-1:0]     axi_bid,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [ID_W-1:0]     axi_arid,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic [ID_W-1:0]     axi_rid,
  output logic                axi_rlast
);

  localparam int          STRB_W   = DATA_W / 8;
  localparam int unsigned LG_BYTES = $clog2(STRB_W);
  localparam int          RAM_AW   = $clog2(DEPTH);
  localparam logic [3:0]  LAT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  // Low during reset and for the edge that releases it, so address readies
  // come up one edge after rst_n deasserts rather than during reset.
  logic r_live;

  // Out-of-reset flag gating the address-channel readies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------------------------------------------------------- write side
  w_state_e          r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen;
  logic [ID_W-1:0]   r_wid;
  logic [7:0]        r_wbeat;
  logic              r_werr;

  logic        w_aw_hs, w_w_hs, w_b_hs;
  logic [63:0] w_widx;
  logic        w_w_oor, w_w_last_beat, w_w_beat_err;

  assign w_aw_hs       = axi_awvalid & axi_awready;
  assign w_w_hs        = axi_wvalid & axi_wready;
  assign w_b_hs        = axi_bvalid & axi_bready;
  assign w_widx        = beat_index(64'(r_waddr), r_wbeat, LG_BYTES);
  assign w_w_oor       = (w_widx >= 64'(DEPTH));
  assign w_w_last_beat = (r_wbeat == r_wlen);
  // A beat is bad if it falls outside storage or its wlast disagrees with the count.
  assign w_w_beat_err  = w_w_oor | (axi_wlast != w_w_last_beat);

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write FSM next-state: address, then awlen+1 data beats, then one response.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_w_last_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write burst context: latch AW fields, count beats, accumulate the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wid   <= '0;
      r_wbeat <= '0;
      r_werr  <= 1'b0;
    end else if (w_aw_hs) begin
      r_waddr <= axi_awaddr;
      r_wlen  <= axi_awlen;
      r_wid   <= axi_awid;
      r_wbeat <= '0;
      r_werr  <= 1'b0;
    end else if (w_w_hs) begin
      r_wbeat <= r_wbeat + 8'd1;
      r_werr  <= r_werr | w_w_beat_err;
    end
  end

  // Write channel outputs decoded from state.
  always_comb begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = RESP_OKAY;
    axi_bid     = '0;
    case (r_wstate)
      W_IDLE: axi_awready = r_live;
      W_DATA: axi_wready  = 1'b1;
      W_RESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = r_werr ? RESP_SLVERR : RESP_OKAY;
        axi_bid    = r_wid;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- read side
  r_state_e          r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_rlen;
  logic [ID_W-1:0]   r_rid;
  logic [7:0]        r_rbeat;
  logic [3:0]        r_rlat;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;

  logic              w_ar_hs, w_r_hs;
  logic              w_rload;
  logic [63:0]       w_rload_base;
  logic [7:0]        w_rload_beat, w_rload_len;
  logic [63:0]       w_ridx;
  logic              w_r_oor;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_ar_hs = axi_arvalid & axi_arready;
  assign w_r_hs  = axi_rvalid & axi_rready;
  assign w_ridx  = beat_index(w_rload_base, w_rload_beat, LG_BYTES);
  assign w_r_oor = (w_ridx >= 64'(DEPTH));

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read FSM next-state: a zero latency skips straight to data.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = (RD_LATENCY == 0) ? R_DATA : R_LAT;
      R_LAT:   if (r_rlat == 4'd0) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Pick when to load the R output register and which beat to fetch.
  always_comb begin
    w_rload      = 1'b0;
    w_rload_base = 64'(r_raddr);
    w_rload_beat = r_rbeat;
    w_rload_len  = r_rlen;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs && (RD_LATENCY == 0)) begin
          w_rload      = 1'b1;
          w_rload_base = 64'(axi_araddr);
          w_rload_beat = 8'd0;
          w_rload_len  = axi_arlen;
        end
      end
      R_LAT: begin
        if (r_rlat == 4'd0) begin
          w_rload      = 1'b1;
          w_rload_beat = 8'd0;
        end
      end
      R_DATA: begin
        if (w_r_hs && !r_rlast) begin
          w_rload      = 1'b1;
          w_rload_beat = r_rbeat + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Read burst context, latency countdown and the registered R beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rid   <= '0;
      r_rlat  <= '0;
      r_rbeat <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_raddr <= axi_araddr;
        r_rlen  <= axi_arlen;
        r_rid   <= axi_arid;
        r_rlat  <= LAT_INIT;
      end else if (r_rstate == R_LAT && r_rlat != 4'd0) begin
        r_rlat <= r_rlat - 4'd1;
      end
      if (w_rload) begin
        r_rbeat <= w_rload_beat;
        r_rdata <= w_r_oor ? '0 : w_ram_rdata;
        r_rresp <= w_r_oor ? RESP_SLVERR : RESP_OKAY;
        r_rlast <= (w_rload_beat == w_rload_len);
      end
    end
  end

  // Read channel outputs decoded from state.
  always_comb begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rid     = '0;
    axi_rlast   = 1'b0;
    axi_rdata   = r_rdata;
    axi_rresp   = r_rresp;
    case (r_rstate)
      R_IDLE: axi_arready = r_live;
      R_DATA: begin
        axi_rvalid = 1'b1;
        axi_rid    = r_rid;
        axi_rlast  = r_rlast;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ storage
  hacd_axi_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW),
    .STRB_W (STRB_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_w_hs & ~w_w_oor),
    .i_waddr (w_widx[RAM_AW-1:0]),
    .i_wdata (axi_wdata),
    .i_wstrb (axi_wstrb),
    .i_raddr (w_ridx[RAM_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_hacd_axi4_mem_model.sv
// Directed plus randomized bench for the AXI4 slave memory model.
// Reference model: byte-accurate associative word store updated per accepted beat.
// Reads are compared beat by beat, including stability while rready is low.
module tb_hacd_axi4_mem_model;

  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 64;
  localparam int ID_W       = 4;
  localparam int DEPTH      = 4096;
  localparam int RD_LATENCY = 2;
  localparam int STRB_W     = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                axi_awvalid = 1'b0, axi_awready;
  logic [ADDR_W-1:0]   axi_awaddr = '0;
  logic [7:0]          axi_awlen = '0;
  logic [ID_W-1:0]     axi_awid = '0;
  logic                axi_wvalid = 1'b0, axi_wready;
  logic [DATA_W-1:0]   axi_wdata = '0;
  logic [STRB_W-1:0]   axi_wstrb = '0;
  logic                axi_wlast = 1'b0;
  logic                axi_bvalid, axi_bready = 1'b0;
  logic [1:0]          axi_bresp;
  logic [ID_W-1:0]     axi_bid;
  logic                axi_arvalid = 1'b0, axi_arready;
  logic [ADDR_W-1:0]   axi_araddr = '0;
  logic [7:0]          axi_arlen = '0;
  logic [ID_W-1:0]     axi_arid = '0;
  logic                axi_rvalid, axi_rready = 1'b0;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic [ID_W-1:0]     axi_rid;
  logic                axi_rlast;

  always #5 clk = ~clk;

  hacd_axi4_mem_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awid(axi_awid),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arid(axi_arid),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rid(axi_rid), .axi_rlast(axi_rlast)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model [longint];
  logic [DATA_W-1:0] wbuf [256];
  logic [STRB_W-1:0] sbuf [256];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word index of beat k: start byte address divided by bytes per beat, plus k.
  function automatic longint widx(input logic [63:0] addr, input int k);
    return longint'(addr / 64'(STRB_W)) + longint'(k);
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] v;
    for (int w = 0; w < DATA_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_write(input longint ix, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    logic [DATA_W-1:0] cur;
    if (ix >= DEPTH) return;
    cur = model.exists(ix) ? model[ix] : '0;
    for (int b = 0; b < STRB_W; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    model[ix] = cur;
  endtask

  task automatic fill(input int len, input int strb_mode, input int kind);
    for (int k = 0; k <= len; k++) begin
      wbuf[k] = (kind == 1) ? DATA_W'(k) : rand_word();
      sbuf[k] = (strb_mode == 0) ? '1 : STRB_W'($urandom);
    end
  endtask

  // bad_last >= 0 drives wlast on that beat instead of the final one;
  // abort_after >= 0 stops driving after that beat is accepted.
  task automatic axi_write(input logic [63:0] addr, input int len, input logic [3:0] id,
                           input int bad_last, input int abort_after, input string tag);
    logic exp_err;
    int   cyc;
    exp_err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (widx(addr, k) >= DEPTH) exp_err = 1'b1;
      if (bad_last >= 0 && ((k == bad_last) != (k == len))) exp_err = 1'b1;
    end
    @(posedge clk); #1;
    axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = 8'(len); axi_awid = id;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); if (axi_awready) break;
      @(posedge clk); #1;
    end
    check({tag, "_aw_timeout"}, 512'(cyc < 100), 512'(1));
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b1; axi_wdata = wbuf[k]; axi_wstrb = sbuf[k];
      axi_wlast = (bad_last >= 0) ? (k == bad_last) : (k == len);
      for (cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk); if (axi_wready) break;
        @(posedge clk); #1;
      end
      check({tag, "_w_timeout"}, 512'(cyc < 100), 512'(1));
      model_write(widx(addr, k), wbuf[k], sbuf[k]);
      if (k == abort_after) begin
        @(posedge clk); #1;
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); if (axi_bvalid) break;
      @(posedge clk); #1;
    end
    check({tag, "_b_timeout"}, 512'(cyc < 100), 512'(1));
    check({tag, "_bresp"}, 512'(axi_bresp), 512'(exp_err ? 2'b10 : 2'b00));
    check({tag, "_bid"}, 512'(axi_bid), 512'(id));
    @(posedge clk); #1;
    axi_bready = 1'b0;
    check({tag, "_awready_after_b"}, 512'(axi_awready), 512'(1));
  endtask

  // mode 0: rready always high; 1: alternating 1/0; 2: random.
  task automatic axi_read(input logic [63:0] addr, input int len, input logic [3:0] id,
                          input int mode, input string tag);
    int cyc, k, first;
    bit stalled;
    logic [511:0] snap;
    logic [DATA_W-1:0] ed;
    logic [1:0] er;
    longint ix;
    @(posedge clk); #1;
    axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = 8'(len); axi_arid = id;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); if (axi_arready) break;
      @(posedge clk); #1;
    end
    check({tag, "_ar_timeout"}, 512'(cyc < 100), 512'(1));
    k = 0; cyc = 0; first = -1; stalled = 0; snap = '0;
    while (k <= len && cyc < 3000) begin
      @(posedge clk); #1;
      axi_arvalid = 1'b0;
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = (cyc % 2 == 0);
        default: axi_rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); cyc++;
      if (axi_rvalid) begin
        if (first < 0) first = cyc;
        if (stalled) check({tag, "_stall_stable"}, 512'({axi_rdata, axi_rresp, axi_rlast, axi_rid}), snap);
        if (axi_rready) begin
          ix = widx(addr, k);
          if (ix >= DEPTH) begin ed = '0; er = 2'b10; end
          else begin ed = model[ix]; er = 2'b00; end
          check({tag, "_rdata"}, 512'(axi_rdata), 512'(ed));
          check({tag, "_rresp"}, 512'(axi_rresp), 512'(er));
          check({tag, "_rid"}, 512'(axi_rid), 512'(id));
          check({tag, "_rlast"}, 512'(axi_rlast), 512'(k == len));
          k++; stalled = 0;
        end else begin
          stalled = 1;
          snap = 512'({axi_rdata, axi_rresp, axi_rlast, axi_rid});
        end
      end
    end
    check({tag, "_r_beats"}, 512'(k), 512'(len + 1));
    check({tag, "_first_latency"}, 512'(first), 512'(RD_LATENCY + 1));
    @(posedge clk); #1;
    axi_rready = 1'b0;
    check({tag, "_rvalid_after_last"}, 512'(axi_rvalid), 512'(0));
    check({tag, "_arready_after_last"}, 512'(axi_arready), 512'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #22;
    check("reset_valids_readies",
          512'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast}), 512'(0));
    check("reset_codes_ids", 512'({axi_bresp, axi_rresp, axi_bid, axi_rid}), 512'(0));
    check("reset_rdata", 512'(axi_rdata), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("awready_low_before_edge", 512'(axi_awready), 512'(0));
    @(posedge clk); #1;
    check("awready_up", 512'(axi_awready), 512'(1));
    check("arready_up", 512'(axi_arready), 512'(1));

    // W beats before any AW stall
    axi_wvalid = 1'b1; axi_wstrb = '1; axi_wlast = 1'b1;
    @(negedge clk);
    check("w_stall_before_aw_0", 512'(axi_wready), 512'(0));
    @(negedge clk);
    check("w_stall_before_aw_1", 512'(axi_wready), 512'(0));
    @(posedge clk); #1;
    axi_wvalid = 1'b0; axi_wlast = 1'b0;

    // Single write then read
    wbuf[0] = {32{8'hA5}}; sbuf[0] = '1;
    axi_write(64'h40, 0, 4'h3, -1, -1, "single_w");
    axi_read(64'h40, 0, 4'h5, 0, "single_r");

    // Byte masking
    wbuf[0] = '0; sbuf[0] = '1;
    axi_write(64'h0, 0, 4'h1, -1, -1, "mask_clear");
    wbuf[0] = '1; sbuf[0] = 32'h0000_000F;
    axi_write(64'h0, 0, 4'h2, -1, -1, "mask_w");
    axi_read(64'h0, 0, 4'h2, 0, "mask_r");
    check("mask_model_value", 512'(model[0]), 512'(32'hFFFF_FFFF));

    // Burst of beat indices read back with toggling rready
    fill(7, 0, 1);
    axi_write(64'h100, 7, 4'h7, -1, -1, "burst_w");
    axi_read(64'h100, 7, 4'h9, 1, "burst_r");

    // Concurrent write to 0x1000 and read of previously written 0x2000
    fill(3, 0, 0);
    axi_write(64'h2000, 3, 4'h4, -1, -1, "pre2000_w");
    fill(5, 0, 0);
    fork
      axi_write(64'h1000, 5, 4'hA, -1, -1, "conc_w");
      axi_read(64'h2000, 3, 4'hB, 2, "conc_r");
    join
    axi_read(64'h1000, 5, 4'hC, 0, "conc_check");

    // Out of range write: dropped, must not alias onto word 0
    fill(0, 0, 0);
    axi_write(64'(DEPTH * 32), 0, 4'h6, -1, -1, "oor_w");
    axi_read(64'h0, 0, 4'h6, 0, "oor_noalias_r");

    // Burst straddling the top of storage
    fill(3, 0, 0);
    axi_write(64'((DEPTH - 2) * 32), 3, 4'hD, -1, -1, "edge_w");
    axi_read(64'((DEPTH - 2) * 32), 3, 4'hD, 2, "edge_r");

    // Early wlast
    fill(3, 0, 0);
    axi_write(64'h500, 3, 4'hE, 1, -1, "early_wlast_w");
    axi_read(64'h500, 3, 4'hE, 0, "early_wlast_r");

    // Out of range read
    axi_read(64'(DEPTH * 32), 1, 4'hF, 0, "oor_r");

    // Randomized bursts: full-strobe fill, random-strobe overwrite, random-ready read
    for (int it = 0; it < 6; it++) begin
      logic [63:0] a;
      int l;
      a = 64'($urandom_range(256, 3000)) * 64'(STRB_W) + 64'($urandom_range(0, STRB_W - 1));
      l = $urandom_range(0, 15);
      fill(l, 0, 0);
      axi_write(a, l, 4'($urandom), -1, -1, "rnd_fill");
      fill(l, 1, 0);
      axi_write(a, l, 4'($urandom), -1, -1, "rnd_strb");
      axi_read(a, l, 4'($urandom), 2, "rnd_r");
    end

    // Maximum length burst
    fill(255, 0, 0);
    axi_write(64'h8000, 255, 4'h1, -1, -1, "len255_w");
    axi_read(64'h8000, 255, 4'h2, 0, "len255_r");

    // Reset in the middle of a write burst
    fill(7, 0, 0);
    axi_write(64'h3000, 7, 4'h3, -1, -1, "rst_old_w");
    fill(7, 0, 0);
    axi_write(64'h3000, 7, 4'h3, -1, 2, "rst_abort_w");
    rst_n = 1'b0;
    #1;
    check("rst_async_wready", 512'(axi_wready), 512'(0));
    @(negedge clk);
    check("rst_valids_low", 512'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_bvalid", 512'(axi_bvalid), 512'(0));
    axi_read(64'h3000, 7, 4'h8, 0, "rst_after_r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hacd_axi4_mem_model.md
Name: hacd_axi4_mem_model

Overview:
Parametrised, synthesizable AXI4 slave memory for the HACD memory-controller path. It replaces the behavioural test memory.
- Independent read and write channel FSMs, both able to run at the same time.
- INCR bursts, byte-lane write strobes, B-channel responses and ID echo.
- Programmable read latency.
- Bounded storage; accesses outside it are reported with SLVERR.
- Sits behind the HAWK/HACD AXI master in place of the DDR controller for simulation and FPGA bring-up.

Parameters:
DATA_W, 256, data bus width in bits; power of two, at least 32; beat stride is DATA_W/8 bytes.
ADDR_W, 64, byte address width.
ID_W, 4, AXI ID width.
DEPTH, 4096, storage depth in DATA_W words; power of two.
RD_LATENCY, 2, idle cycles between AR handshake and first R beat; legal range 0..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_awaddr  in  ADDR_W  burst start byte address
axi_awlen  in  8  beats minus one
axi_awid  in  ID_W  write ID
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte enables
axi_wlast  in  1  last write beat
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_bresp  out  2  write response code
axi_bid  out  ID_W  echoed awid
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_araddr  in  ADDR_W  burst start byte address
axi_arlen  in  8  beats minus one
axi_arid  in  ID_W  read ID
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_rdata  out  DATA_W  read data
axi_rresp  out  2  read response code
axi_rid  out  ID_W  echoed arid
axi_rlast  out  1  last read beat

Behaviour:
- Reset values: every valid and ready output is 0; bresp, rresp, rdata, bid, rid and rlast are 0.
- awready and arready rise in the first clk edge after rst_n deasserts. Memory contents are not reset.
- Addressing:
  - beat k of a burst uses byte address start + k*(DATA_W/8); INCR only.
  - word index = byte address >> log2(DATA_W/8).
  - A beat is out of range if its word index >= DEPTH. Such a write beat is dropped; such a read beat returns rdata 0 with rresp SLVERR (2'b10).
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch addr/len/id; next cycle awready=0, wready=1.
  - W_DATA: on each W handshake, update only the bytes whose wstrb bit is 1. wstrb all zero is legal and writes nothing.
  - After beat awlen is accepted: wready=0, bvalid=1 next cycle.
  - bresp=SLVERR if any beat was out of range, or if wlast did not equal (beat==awlen) on any beat; otherwise OKAY. bid = latched awid.
  - W_RESP: hold bvalid, bresp and bid until bready; awready=1 in the cycle after the B handshake.
  - W beats presented before the AW handshake stall (wready=0).
- Read FSM, states R_IDLE -> R_LAT -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch fields; arready=0.
  - R_LAT: wait RD_LATENCY cycles. With RD_LATENCY=0, first rvalid appears the cycle after the AR handshake.
  - R_DATA: present registered beat data with rid; rlast=1 on beat arlen.
  - rdata, rresp, rlast and rid stay stable while rvalid and !rready.
  - Next beat is loaded in the cycle after each handshake, so back-to-back beats run at one per cycle when rready stays high.
  - After the last handshake, rvalid=0 and arready=1 in the next cycle.
- Concurrency: read and write FSMs are independent. One outstanding burst per direction.
- Same-word collision: a read beat loaded in the same cycle a write beat commits sees old data. Loads in later cycles see new data.
- awlen/arlen 255: 256 beats; the beat counter is 8 bits and must not wrap early.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronous). Write beats already committed remain in memory; no B response is issued for the aborted burst.

Decomposition:
- Package hacd_axi_mem_pkg holds:
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the write and read state enums;
  - function beat_index(addr, k) returning the word index.
- One sub-module, hacd_axi_mem_ram: DEPTH x DATA_W storage with one byte-enabled synchronous write port and one combinational read port.
- FSMs live in the top module.

Test Plan:
- Single write then read: AW addr 0x40, len 0, wdata A5.., wstrb all ones -> bresp OKAY, bid echoed. AR 0x40, len 0 -> rdata A5.., rlast=1, first rvalid exactly RD_LATENCY+1 cycles after the AR handshake.
- Byte masking: write 0 to word 0x00, then write FF..FF with wstrb 0x0000000F -> read returns 0x..00FFFFFFFF in the low 4 bytes and 0 elsewhere.
- Burst with backpressure: len 7 write of the beat index values, then a read with rready toggling 1/0 -> 8 beats 0..7 in order, rlast only on beat 7, rdata stable during stalls.
- Concurrent traffic: a write burst to 0x1000 and a read burst to 0x2000 issued in the same cycle -> both complete, and the read returns the previously written 0x2000 data.
- Error cases: AW addr = DEPTH*32 -> bresp SLVERR and memory unchanged. A len 3 write with wlast on beat 1 -> SLVERR. AR out of range -> rresp SLVERR with rdata 0.
- Reset mid-burst: assert rst_n low after beat 2 of a len 7 write -> all valids low next sample. After release, read -> beats 0-2 hold the new data, beats 3-7 hold the old data.
